// File: rtl/shift_pkg.sv
// Shared definitions for the shift register family: deserializer FSM states
// and the default word width, also used by the shifter's bench.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PARITY  = 2'd2
   } deser_state_e;

   localparam int DEFAULT_WORD_WIDTH = 8;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial-in / word-out bus of shift_deserializer.
// parity_err exists only when SHIFT_DESER_PARITY_EN is defined.
interface shift_deserializer_if #(
   parameter int WORD_WIDTH = shift_pkg::DEFAULT_WORD_WIDTH
);
   logic                  bit_en;
   logic                  serial_in;
   logic                  sof;
   logic                  out_ready;
   logic                  overrun_clr;
   logic [WORD_WIDTH-1:0] word_out;
   logic                  out_valid;
   logic                  overrun;
   logic                  busy;
`ifdef SHIFT_DESER_PARITY_EN
   logic                  parity_err;
`endif

   // Producer of the serial stream and consumer of the words
   modport master (
      output bit_en, serial_in, sof, out_ready, overrun_clr,
      input  word_out, out_valid, overrun, busy
`ifdef SHIFT_DESER_PARITY_EN
      , input parity_err
`endif
   );

   // The deserializer itself
   modport slave (
      input  bit_en, serial_in, sof, out_ready, overrun_clr,
      output word_out, out_valid, overrun, busy
`ifdef SHIFT_DESER_PARITY_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/shift_deser_outreg.sv
// Output holding register: one-word valid/ready buffer with sticky overrun.
// A completed word is never stalled; if the buffer cannot take it the word
// is dropped and overrun latches. parity_err only with SHIFT_DESER_PARITY_EN.
module shift_deser_outreg #(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  sclr_n,
   input  logic                  push,
   input  logic [WORD_WIDTH-1:0] push_word,
`ifdef SHIFT_DESER_PARITY_EN
   input  logic                  push_perr,
   output logic                  parity_err,
`endif
   input  logic                  out_ready,
   input  logic                  overrun_clr,
   output logic [WORD_WIDTH-1:0] word_out,
   output logic                  out_valid,
   output logic                  overrun
);

   // Buffer is free if empty or being drained on this same edge
   logic can_load;
   assign can_load = !out_valid || out_ready;

   // Load / drain the holding register
   always_ff @(posedge clock) begin
      if (!sclr_n) begin
         word_out  <= '0;
         out_valid <= 1'b0;
      end else if (push && can_load) begin
         word_out  <= push_word;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky overrun; a drop on the same edge wins over the clear
   always_ff @(posedge clock) begin
      if (!sclr_n)
         overrun <= 1'b0;
      else if (push && !can_load)
         overrun <= 1'b1;
      else if (overrun_clr)
         overrun <= 1'b0;
   end

`ifdef SHIFT_DESER_PARITY_EN
   // One-cycle parity error pulse, only alongside a word that actually loads
   always_ff @(posedge clock) begin
      if (!sclr_n)
         parity_err <= 1'b0;
      else
         parity_err <= push && can_load && push_perr;
   end
`endif

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receive stage behind the shift register's shiftout.
// Framing FSM, bit counter and assembly register live here; delivery and
// overrun handling live in shift_deser_outreg.
// Optional: SHIFT_DESER_PARITY_EN adds a trailing even-parity bit per word.
module shift_deserializer
   import shift_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                 clock,
   input  logic                 sclr_n,
   shift_deserializer_if.slave  bus
);

   localparam int CW = $clog2(WORD_WIDTH + 1);

   deser_state_e          state;
   logic [CW-1:0]         cnt;
   logic [WORD_WIDTH-1:0] shreg;
   logic [WORD_WIDTH-1:0] asm_next;
   logic [WORD_WIDTH-1:0] asm_first;
   logic                  last_bit;
   logic                  push;
   logic [WORD_WIDTH-1:0] push_word;

   // Shifting toward the MSB places bit i at WORD_WIDTH-1-i after a full word;
   // shifting toward the LSB places it at i.
   generate
      if (MSB_FIRST) begin : g_msb
         assign asm_next  = {shreg[WORD_WIDTH-2:0], bus.serial_in};
         assign asm_first = {{(WORD_WIDTH-1){1'b0}}, bus.serial_in};
      end else begin : g_lsb
         assign asm_next  = {bus.serial_in, shreg[WORD_WIDTH-1:1]};
         assign asm_first = {bus.serial_in, {(WORD_WIDTH-1){1'b0}}};
      end
   endgenerate

   assign last_bit = (cnt == CW'(WORD_WIDTH - 1));

`ifdef SHIFT_DESER_PARITY_EN
   logic push_perr;

   // Word is handed over when its parity bit arrives
   always_comb begin
      push      = bus.bit_en && !bus.sof && (state == PARITY);
      push_word = shreg;
      push_perr = (^shreg) ^ bus.serial_in;
   end
`else
   // Word is handed over on the edge that samples its last bit
   always_comb begin
      push      = bus.bit_en && !bus.sof && (state == COLLECT) && last_bit;
      push_word = asm_next;
   end
`endif

   // Framing FSM with counter, assembly register and registered busy
   always_ff @(posedge clock) begin
      if (!sclr_n) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         bus.busy <= 1'b0;
      end else if (bus.bit_en) begin
         if (bus.sof) begin
            // sof always restarts, dropping any partial word silently
            state    <= COLLECT;
            cnt      <= CW'(1);
            shreg    <= asm_first;
            bus.busy <= 1'b1;
         end else begin
            case (state)
               COLLECT: begin
                  shreg <= asm_next;
                  if (last_bit) begin
                     cnt <= '0;
`ifdef SHIFT_DESER_PARITY_EN
                     state <= PARITY;
`else
                     state    <= IDLE;
                     bus.busy <= 1'b0;
`endif
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               PARITY: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
               default: ;  // IDLE: stray bits without sof are ignored
            endcase
         end
      end
   end

   shift_deser_outreg #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_outreg (
      .clock       (clock),
      .sclr_n      (sclr_n),
      .push        (push),
      .push_word   (push_word),
`ifdef SHIFT_DESER_PARITY_EN
      .push_perr   (push_perr),
      .parity_err  (bus.parity_err),
`endif
      .out_ready   (bus.out_ready),
      .overrun_clr (bus.overrun_clr),
      .word_out    (bus.word_out),
      .out_valid   (bus.out_valid),
      .overrun     (bus.overrun)
   );

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receive stage placed directly downstream of the team's configurable shift register, consuming its `shiftout` bit stream. It reassembles bits into WORD_WIDTH-bit words, frames them with a start-of-frame strobe, and presents each word on a valid/ready output. A word that cannot be delivered raises a sticky overrun flag instead of stalling the serial side.

## Interface
- WORD_WIDTH, 8, bits per assembled word (≥2).
- MSB_FIRST, 1, 1: first received bit lands in word_out[WORD_WIDTH-1], matching a left-shifting source; 0: first bit lands in word_out[0].

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- sclr_n  in  1  reset; synchronous, active-low.
- bit_en  in  1  serial_in is valid this cycle.
- serial_in  in  1  serial data bit (the upstream shifter's `shiftout`).
- sof  in  1  qualified by bit_en; marks the current bit as bit 0 of a new word.
- out_ready  in  1  consumer accepts word_out this cycle.
- overrun_clr  in  1  clears the overrun flag.
- word_out  out  WORD_WIDTH  assembled word, stable while out_valid && !out_ready.
- out_valid  out  1  word_out holds an undelivered word.
- overrun  out  1  sticky: a completed word was dropped.
- busy  out  1  high in COLLECT (and PARITY when compiled in).
- parity_err  out  1  present only with SHIFT_DESER_PARITY_EN.

## Operation
- States: IDLE, COLLECT, PARITY (PARITY only with the macro).
- IDLE: bits with bit_en=1, sof=0 are ignored. bit_en=1, sof=1 → store bit 0, bit counter=1, go COLLECT.
- COLLECT: each bit_en=1 stores the next bit and increments the counter. Counter width is $clog2(WORD_WIDTH+1).
- Storing bit WORD_WIDTH-1 completes the word and goes to IDLE (or PARITY).
- Bit index i goes to position WORD_WIDTH-1-i when MSB_FIRST=1, and to position i otherwise.
- sof=1 with bit_en=1 in COLLECT or PARITY: the partial word is discarded silently and the bit is taken as bit 0 of a new word. No overrun is raised.
- bit_en=0: nothing changes; sof and serial_in are ignored.
- Completion, output register empty (or emptying this edge via out_ready): the word loads into word_out and out_valid=1.
- Completion, out_valid=1, out_ready=0: the new word is dropped, overrun←1, word_out is unchanged.
- Handshake: transfer occurs on an edge with out_valid && out_ready. out_valid falls next cycle unless a new word loads on the same edge, in which case out_valid stays 1 with the new word.
- overrun: set has priority over overrun_clr on the same edge.
- sclr_n=0: state IDLE, counter 0, shift register 0, word_out 0, out_valid 0, overrun 0, busy 0, parity_err 0. This applies mid-word and mid-handshake; the partial word and any pending output are lost.

## Timing
- Latency: out_valid rises on the cycle after the edge that sampled the last data bit (the parity bit when compiled in).
- Throughput: one word every WORD_WIDTH consecutive bit_en cycles, with no dead cycle between words. A back-to-back sof is required for each word.
- word_out and out_valid are registered; out_ready has no combinational path to any output.
- busy is registered and falls on the completion edge.

## Configuration
- SHIFT_DESER_PARITY_EN defined:
  - After bit WORD_WIDTH-1 the FSM enters PARITY and consumes one extra bit_en bit as even parity over the word.
  - The word is delivered regardless of parity.
  - parity_err is a registered pulse, high one cycle, aligned with out_valid rising, when the XOR of word and parity bit is 1.
  - On the overrun drop path parity_err stays 0.
- SHIFT_DESER_PARITY_EN undefined: no PARITY state and no parity_err port; a word is exactly WORD_WIDTH bits.

## Structure
- Shared package shift_pkg: FSM state enum (IDLE, COLLECT, PARITY) and the default word-width constant, shared with the shifter's bench.
- One sub-module, shift_deser_outreg: the output holding register with valid/ready and overrun logic. The FSM, counter and assembly register stay in the top.

## Test plan
- WORD_WIDTH=8, MSB_FIRST=1, bits 1,0,0,0,1,0,0,0 with sof on the first → word_out=8'h88, out_valid=1 one cycle after the 8th bit.
- Same bits with MSB_FIRST=0 → word_out=8'h11.
- Two back-to-back words 8'hA5, 8'h3C with out_ready=0 throughout → first word held as 8'hA5, overrun=1 after the second completes. overrun_clr → overrun=0.
- sof reasserted after 5 bits of 8'hFF, then a full 8'h0F sent → only 8'h0F delivered, overrun=0.
- sclr_n=0 for one cycle after 4 bits → all outputs 0, busy=0. The next 4 bits without sof produce no word.
- Macro defined: 8'h81 followed by parity 0 → delivered, parity_err=0. 8'h81 followed by parity 1 → delivered, parity_err pulses 1.
